// File: rtl/id_ex_pipe_reg_pkg.sv
// Control-bundle types shared by the controller, the ID/EX register and EX.
// Also holds the BUBBLE constants that an empty pipeline slot carries.
package control_signals;

    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM = 2'd1;
    localparam logic [1:0] MEMTOREG_PC4 = 2'd2;

    localparam int ALUSEL_W = 4;

    typedef struct packed {
        logic                Jump;
        logic                Branch;
        logic                BrUn;
        logic                ALUSrcA;   // 1: PC as operand A
        logic                ALUSrcB;   // 1: immediate as operand B
        logic [ALUSEL_W-1:0] ALUSel;
    } ex_control_t;

    typedef struct packed {
        logic       MemRW;              // 1: store
        logic       MemRead;
        logic [2:0] MemFunct3;          // access width / sign
    } mem_control_t;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] MemtoReg;
    } wb_control_t;

    localparam ex_control_t  EX_BUBBLE  = '0;
    localparam mem_control_t MEM_BUBBLE = '0;
    localparam wb_control_t  WB_BUBBLE  = '0;

    // A writeback sourced from memory marks the EX instruction as a load.
    function automatic logic is_load(input wb_control_t wb);
        return wb.RegWrite && (wb.MemtoReg == MEMTOREG_MEM);
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_hazard_unit.sv
// Load-use detection between the ID instruction and the load sitting in EX,
// plus the IF/ID hold that freezes PC while EX stalls or a bubble goes in.
module id_ex_pipe_reg_hazard_unit
    import control_signals::*;
(
    input  logic        ex_valid,
    input  wb_control_t ex_wb_ctrl,
    input  logic [4:0]  ex_rd_addr,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        flush,
    input  logic        ex_stall,
    output logic        load_use,
    output logic        hold_if_id,
    output logic        bubble_insert
);

    logic rs1_hit;
    logic rs2_hit;
    logic ex_is_load;

    assign ex_is_load = ex_valid && is_load(ex_wb_ctrl) && (ex_rd_addr != 5'd0);
    assign rs1_hit    = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
    assign rs2_hit    = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);

    assign load_use      = id_valid && ex_is_load && (rs1_hit || rs2_hit);
    assign hold_if_id    = (load_use || ex_stall) && !flush;
    // A load-use bubble only lands when neither flush nor stall outranks it.
    assign bubble_insert = load_use && !ex_stall && !flush;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX boundary register: one-cycle transfer of the decoded bundle with
// flush > stall > load-use bubble > normal load priority, plus perf counters.
module id_ex_pipe_reg
    import control_signals::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [4:0]         id_rs1_addr,
    input  logic [4:0]         id_rs2_addr,
    input  logic [4:0]         id_rd_addr,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  ex_control_t        id_ex_ctrl,
    input  mem_control_t       id_mem_ctrl,
    input  wb_control_t        id_wb_ctrl,
    input  logic               flush,
    input  logic               ex_stall,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [4:0]         ex_rs1_addr,
    output logic [4:0]         ex_rs2_addr,
    output logic [4:0]         ex_rd_addr,
    output ex_control_t        ex_ex_ctrl,
    output mem_control_t       ex_mem_ctrl,
    output wb_control_t        ex_wb_ctrl,
    output logic               hold_if_id,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   stall_cycles
);

    logic load_use;
    logic bubble_insert;
    logic capture;
    logic empty_slot;

    id_ex_pipe_reg_hazard_unit u_hazard (
        .ex_valid      (ex_valid),
        .ex_wb_ctrl    (ex_wb_ctrl),
        .ex_rd_addr    (ex_rd_addr),
        .id_valid      (id_valid),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .flush         (flush),
        .ex_stall      (ex_stall),
        .load_use      (load_use),
        .hold_if_id    (hold_if_id),
        .bubble_insert (bubble_insert)
    );

    // Flush overrides the stall hold; otherwise a stall freezes the register.
    assign capture    = flush || !ex_stall;
    // Invalid ID slots are forced to BUBBLE so x on ctrl inputs never escapes.
    assign empty_slot = flush || load_use || !id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ex_ex_ctrl  <= EX_BUBBLE;
            ex_mem_ctrl <= MEM_BUBBLE;
            ex_wb_ctrl  <= WB_BUBBLE;
        end else if (capture) begin
            if (empty_slot) begin
                ex_valid    <= 1'b0;
                ex_pc       <= '0;
                ex_rs1_data <= '0;
                ex_rs2_data <= '0;
                ex_imm      <= '0;
                ex_rs1_addr <= '0;
                ex_rs2_addr <= '0;
                ex_rd_addr  <= '0;
                ex_ex_ctrl  <= EX_BUBBLE;
                ex_mem_ctrl <= MEM_BUBBLE;
                ex_wb_ctrl  <= WB_BUBBLE;
            end else begin
                ex_valid    <= 1'b1;
                ex_pc       <= id_pc;
                ex_rs1_data <= id_rs1_data;
                ex_rs2_data <= id_rs2_data;
                ex_imm      <= id_imm;
                ex_rs1_addr <= id_rs1_addr;
                ex_rs2_addr <= id_rs2_addr;
                ex_rd_addr  <= id_rd_addr;
                ex_ex_ctrl  <= id_ex_ctrl;
                ex_mem_ctrl <= id_mem_ctrl;
                ex_wb_ctrl  <= id_wb_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt   <= '0;
            stall_cycles <= '0;
        end else begin
            if (bubble_insert)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (ex_stall)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: load-use bubbles, stalls, flush priority,
// invalid-slot BUBBLE substitution and asynchronous reset.
module tb_id_ex_pipe_reg;
    import control_signals::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic             id_uses_rs1, id_uses_rs2;
    ex_control_t      id_ex_ctrl;
    mem_control_t     id_mem_ctrl;
    wb_control_t      id_wb_ctrl;
    logic             flush, ex_stall;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    ex_control_t      ex_ex_ctrl;
    mem_control_t     ex_mem_ctrl;
    wb_control_t      ex_wb_ctrl;
    logic             hold_if_id;
    logic [CNT_W-1:0] bubble_cnt, stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_ctrl(id_ex_ctrl), .id_mem_ctrl(id_mem_ctrl), .id_wb_ctrl(id_wb_ctrl),
        .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_ex_ctrl(ex_ex_ctrl), .ex_mem_ctrl(ex_mem_ctrl), .ex_wb_ctrl(ex_wb_ctrl),
        .hold_if_id(hold_if_id), .bubble_cnt(bubble_cnt), .stall_cycles(stall_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = ALU reg-reg, 1 = load, 2 = lui
    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input int kind);
        id_valid    = v;
        id_pc       = pc;
        id_rs1_data = pc + 32'h1000;
        id_rs2_data = pc + 32'h2000;
        id_imm      = pc + 32'h3000;
        id_rs1_addr = rs1;
        id_rs2_addr = rs2;
        id_rd_addr  = rd;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        id_ex_ctrl  = '0;
        id_mem_ctrl = '0;
        id_wb_ctrl  = '0;
        id_wb_ctrl.RegWrite = 1'b1;
        case (kind)
            1: begin
                id_wb_ctrl.MemtoReg  = MEMTOREG_MEM;
                id_mem_ctrl.MemRead  = 1'b1;
                id_mem_ctrl.MemFunct3 = 3'd2;
                id_ex_ctrl.ALUSrcB   = 1'b1;
            end
            2: begin
                id_ex_ctrl.ALUSrcB = 1'b1;
                id_ex_ctrl.ALUSel  = 4'hF;
            end
            default: id_ex_ctrl.ALUSel = 4'h0;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
        set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 0);
        tick(); tick();
        n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        n_cmp++; if (ex_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", ex_pc); end
        n_cmp++; if ({ex_ex_ctrl, ex_mem_ctrl, ex_wb_ctrl} !== '0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", {ex_ex_ctrl, ex_mem_ctrl, ex_wb_ctrl}); end
        n_cmp++; if ({bubble_cnt, stall_cycles} !== '0) begin n_err++; $display("FAIL reset_cnt: got %h/%h want 0/0", bubble_cnt, stall_cycles); end
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 0);
        @(negedge clk); rst = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        set_id(1'b1, 32'h100, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1);   // lw x5
        tick();
        set_id(1'b1, 32'h104, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 0);   // add x6,x5,x1
        #1;
        n_cmp++; if (hold_if_id !== 1'b1) begin n_err++; $display("FAIL lu_hold: got %b want 1", hold_if_id); end
        tick();
        n_cmp++; if (ex_valid !== 1'b0 || ex_wb_ctrl.RegWrite !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got v=%b rw=%b want 0/0", ex_valid, ex_wb_ctrl.RegWrite); end
        n_cmp++; if (bubble_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt: got %0d want 1", bubble_cnt); end
        n_cmp++; if (hold_if_id !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b want 0", hold_if_id); end
        tick();
        n_cmp++; if (ex_valid !== 1'b1 || ex_pc !== 32'h104 || ex_rd_addr !== 5'd6 || ex_rs1_data !== 32'h1104) begin
            n_err++; $display("FAIL lu_advance: got v=%b pc=%h rd=%0d d1=%h want 1/104/6/1104", ex_valid, ex_pc, ex_rd_addr, ex_rs1_data); end
        // both sources hit the same load: still a single bubble
        set_id(1'b1, 32'h108, 5'd3, 5'd0, 5'd7, 1'b1, 1'b0, 1);   // lw x7
        tick();
        set_id(1'b1, 32'h10C, 5'd7, 5'd7, 5'd8, 1'b1, 1'b1, 0);   // add x8,x7,x7
        tick(); tick();
        n_cmp++; if (bubble_cnt !== 32'd2 || ex_pc !== 32'h10C || ex_valid !== 1'b1) begin
            n_err++; $display("FAIL lu_both: got cnt=%0d pc=%h v=%b want 2/10c/1", bubble_cnt, ex_pc, ex_valid); end
    endtask

    task automatic test_no_hazard();
        set_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1);   // lw x0
        tick();
        set_id(1'b1, 32'h204, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 0);   // add x6,x0,x0
        #1;
        n_cmp++; if (hold_if_id !== 1'b0) begin n_err++; $display("FAIL x0_hold: got %b want 0", hold_if_id); end
        tick();
        n_cmp++; if (ex_pc !== 32'h204 || ex_valid !== 1'b1 || bubble_cnt !== 32'd2) begin
            n_err++; $display("FAIL x0_pass: got pc=%h v=%b cnt=%0d want 204/1/2", ex_pc, ex_valid, bubble_cnt); end
        set_id(1'b1, 32'h208, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1);   // lw x5
        tick();
        set_id(1'b1, 32'h20C, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 2);   // lui x5, stale rs fields
        #1;
        n_cmp++; if (hold_if_id !== 1'b0) begin n_err++; $display("FAIL lui_hold: got %b want 0", hold_if_id); end
        tick();
        n_cmp++; if (ex_pc !== 32'h20C || bubble_cnt !== 32'd2) begin
            n_err++; $display("FAIL lui_pass: got pc=%h cnt=%0d want 20c/2", ex_pc, bubble_cnt); end
    endtask

    task automatic test_stall();
        set_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 0);
        tick();
        set_id(1'b1, 32'h304, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 0);
        ex_stall = 1'b1;
        #1;
        n_cmp++; if (hold_if_id !== 1'b1) begin n_err++; $display("FAIL stall_hold: got %b want 1", hold_if_id); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (ex_pc !== 32'h300 || ex_rd_addr !== 5'd9 || ex_imm !== 32'h3300) begin
                n_err++; $display("FAIL stall_keep%0d: got pc=%h rd=%0d imm=%h want 300/9/3300", i, ex_pc, ex_rd_addr, ex_imm); end
        end
        ex_stall = 1'b0;
        n_cmp++; if (stall_cycles !== 32'd3) begin n_err++; $display("FAIL stall_cnt: got %0d want 3", stall_cycles); end
        tick();
        n_cmp++; if (ex_pc !== 32'h304) begin n_err++; $display("FAIL stall_resume: got %h want 304", ex_pc); end
    endtask

    task automatic test_flush();
        set_id(1'b1, 32'h400, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1);   // lw x5
        tick();
        set_id(1'b1, 32'h404, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 0);   // load-use on x5
        ex_stall = 1'b1; flush = 1'b1;
        #1;
        n_cmp++; if (hold_if_id !== 1'b0) begin n_err++; $display("FAIL flush_hold: got %b want 0", hold_if_id); end
        tick();
        ex_stall = 1'b0; flush = 1'b0;
        n_cmp++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || {ex_ex_ctrl, ex_mem_ctrl, ex_wb_ctrl} !== '0) begin
            n_err++; $display("FAIL flush_bubble: got v=%b pc=%h ctrl=%h want 0/0/0", ex_valid, ex_pc, {ex_ex_ctrl, ex_mem_ctrl, ex_wb_ctrl}); end
        n_cmp++; if (bubble_cnt !== 32'd2 || stall_cycles !== 32'd4) begin
            n_err++; $display("FAIL flush_cnt: got %0d/%0d want 2/4", bubble_cnt, stall_cycles); end
    endtask

    task automatic test_invalid_x();
        set_id(1'b1, 32'h500, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 0);
        id_mem_ctrl.MemRW = 1'b1;                                 // sw-like, then invalidate
        tick();
        id_valid    = 1'b0;
        id_ex_ctrl  = 'x;
        id_mem_ctrl = 'x;
        id_wb_ctrl  = 'x;
        id_rd_addr  = 'x;
        #1;
        n_cmp++; if (hold_if_id !== 1'b0) begin n_err++; $display("FAIL inv_hold: got %b want 0", hold_if_id); end
        tick();
        n_cmp++; if (ex_valid !== 1'b0 || ex_mem_ctrl.MemRW !== 1'b0) begin
            n_err++; $display("FAIL inv_slot: got v=%b memrw=%b want 0/0", ex_valid, ex_mem_ctrl.MemRW); end
        n_cmp++; if ({ex_ex_ctrl, ex_mem_ctrl, ex_wb_ctrl} !== '0) begin
            n_err++; $display("FAIL inv_ctrl_x: got %h want 0", {ex_ex_ctrl, ex_mem_ctrl, ex_wb_ctrl}); end
    endtask

    task automatic test_reset_mid();
        set_id(1'b1, 32'h600, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1);   // lw x5
        tick();
        set_id(1'b1, 32'h604, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 0);
        ex_stall = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (ex_valid !== 1'b0 || ex_wb_ctrl.RegWrite !== 1'b0 || ex_pc !== 32'h0) begin
            n_err++; $display("FAIL rstmid_regs: got v=%b rw=%b pc=%h want 0/0/0", ex_valid, ex_wb_ctrl.RegWrite, ex_pc); end
        n_cmp++; if (bubble_cnt !== '0 || stall_cycles !== '0) begin
            n_err++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", bubble_cnt, stall_cycles); end
        ex_stall = 1'b0;
        @(negedge clk); rst = 1'b0;
        tick();
        n_cmp++; if (ex_valid !== 1'b1 || ex_pc !== 32'h604 || bubble_cnt !== '0) begin
            n_err++; $display("FAIL rstmid_after: got v=%b pc=%h cnt=%0d want 1/604/0", ex_valid, ex_pc, bubble_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_stall();
        test_flush();
        test_invalid_x();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
